qqspi_arbiter: RTL

//  Two-port arbiter sharing one qqspi PSRAM/flash controller between requesters (e.g. instruction fetch, data).

---
 rtl/qqspi_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/qqspi_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | qqspi_arbiter: two-port valid/ready arbiter in front of one qqspi controller |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module qqspi_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [22:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_wstrb,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [22:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_wstrb,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        mem_valid,
  output logic [22:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        req0_ready_q, req0_ready_d;
  logic        req1_ready_q, req1_ready_d;
  logic [31:0] req0_rdata_q, req0_rdata_d;
  logic [31:0] req1_rdata_q, req1_rdata_d;
  logic        busy_q, busy_d;
  logic        pick1;

  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    req0_rdata_d = req0_rdata_q;
    req1_rdata_d = req1_rdata_q;
    pick1        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!req1_valid) starve_cnt_d = 4'd0;
        // A still-high mem_ready belongs to the previous access; never grant over it.
        if (!mem_ready && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) begin
            if (PRIORITY_MODE == 0) pick1 = ~last_grant_q;
            else                    pick1 = (starve_cnt_q == STARVE_LIM);
          end else begin
            pick1 = req1_valid;
          end
          mem_addr_d   = pick1 ? req1_addr  : req0_addr;
          mem_wdata_d  = pick1 ? req1_wdata : req0_wdata;
          mem_wstrb_d  = pick1 ? req1_wstrb : req0_wstrb;
          grant_d      = pick1;
          last_grant_d = pick1;
          mem_valid_d  = 1'b1;
          state_d      = ISSUE;
          if (pick1)
            starve_cnt_d = 4'd0;
          else if (req1_valid && starve_cnt_q != 4'hF)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (grant_q) req1_ready_d = 1'b1;
          else         req0_ready_d = 1'b1;
          if (mem_wstrb_q == 4'd0) begin
            if (grant_q) req1_rdata_d = mem_rdata;
            else         req0_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 23'd0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      starve_cnt_q <= 4'd0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      req0_rdata_q <= 32'd0;
      req1_rdata_q <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      req0_rdata_q <= req0_rdata_d;
      req1_rdata_q <= req1_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign req0_rdata = req0_rdata_q;
  assign req1_rdata = req1_rdata_q;

endmodule
`default_nettype wire
